// File: rtl/rv_pkg.sv
// Shared definitions for the single-cycle RV64 integer core.
// Contents: memory geometry, opcode / funct constants, ALU operation enum and
// a 12-bit sign-extension helper.
package rv_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned IMEM_DEPTH = 64;
   localparam int unsigned DMEM_DEPTH = 64;
   localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);
   localparam int unsigned DMEM_AW    = $clog2(DMEM_DEPTH);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;

   // Only instruction bit 30 distinguishes sub from add in this subset.
   localparam int unsigned F7_SUB_BIT = 30;

   typedef enum logic [1:0] {
      ADD,
      SUB,
      AND,
      OR
   } alu_op_t;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
      return {{(XLEN-12){v[11]}}, v};
   endfunction

endpackage

// File: rtl/rv64_cpu_sequential_if.sv
// Data-memory bus between the core (master) and data_memory (slave).
// Signals: addr (doubleword index), wdata, we (write on clock edge),
//          re (read enable), rdata (combinational read data).
interface rv64_cpu_sequential_if;
   import rv_pkg::*;

   logic [DMEM_AW-1:0] addr;
   logic [XLEN-1:0]    wdata;
   logic               we;
   logic               re;
   logic [XLEN-1:0]    rdata;

   modport master (output addr, output wdata, output we, output re, input rdata);
   modport slave  (input addr, input wdata, input we, input re, output rdata);

endinterface

// File: rtl/data_memory.sv
// 64 x 64-bit data store: combinational read, write on rising clk.
// Ports: clk, bus (slave side of rv64_cpu_sequential_if).
// Contents are not touched by the core reset.
module data_memory
   import rv_pkg::*;
(
   input logic                   clk,
   rv64_cpu_sequential_if.slave  bus
);

   logic [XLEN-1:0] memory [DMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (bus.we) begin
         memory[bus.addr] <= bus.wdata;
      end
   end

   assign bus.rdata = bus.re ? memory[bus.addr] : '0;

endmodule

// File: rtl/instruction_memory.sv
// 64 x 32-bit instruction store with a combinational read port.
// Ports: clk, load_en/load_addr/load_data (synchronous load port, tied off
//        when the image is preloaded from outside), addr, data (fetch).
module instruction_memory
   import rv_pkg::*;
(
   input  logic               clk,
   input  logic               load_en,
   input  logic [IMEM_AW-1:0] load_addr,
   input  logic [31:0]        load_data,
   input  logic [IMEM_AW-1:0] addr,
   output logic [31:0]        data
);

   logic [31:0] memory [IMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (load_en) begin
         memory[load_addr] <= load_data;
      end
   end

   assign data = memory[addr];

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit integer register file.
// Ports: clk, reset (async active-low, clears all registers),
//        rs1_addr/rs1_data, rs2_addr/rs2_data (combinational reads),
//        wr_en/wr_addr/wr_data (write on rising clk). x0 is hardwired to 0.
module register_file
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            wr_en,
   input  logic [4:0]      wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] registers [32];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            registers[i] <= '0;
         end
      end else if (wr_en && (wr_addr != 5'd0)) begin
         registers[wr_addr] <= wr_data;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0) ? '0 : registers[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 : registers[rs2_addr];

endmodule

// File: rtl/rv64_cpu_sequential.sv
// Single-cycle RV64 subset core (add, sub, and, or, addi, ld, sd, beq).
// Ports: clk (rising edge), reset (async active-low: PC and registers to 0).
// Every instruction is fetched, decoded, executed and retired in one cycle;
// decoder, immediate generator and ALU are inline.
module rv64_cpu_sequential
   import rv_pkg::*;
(
   input logic clk,
   input logic reset
);

   logic [XLEN-1:0] pc_current;
   logic [XLEN-1:0] pc_next;
   logic [31:0]     instruction;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;

   logic            reg_write;
   logic            branch;
   logic            mem_read;
   logic            mem_to_reg;
   logic            mem_write;
   logic            alu_src;
   alu_op_t         alu_op;
   logic            alu_kill;

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] reg_read_data1;
   logic [XLEN-1:0] reg_read_data2;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            zero;
   logic [XLEN-1:0] mem_read_data;
   logic [XLEN-1:0] reg_write_data;

   rv64_cpu_sequential_if dbus ();

   // Fetch
   instruction_memory imem (
      .clk       (clk),
      .load_en   (1'b0),
      .load_addr ('0),
      .load_data ('0),
      .addr      (pc_current[IMEM_AW+1:2]),
      .data      (instruction)
   );

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign rd     = instruction[11:7];

   // Immediates
   assign imm_i = sext12(instruction[31:20]);
   assign imm_s = sext12({instruction[31:25], instruction[11:7]});
   assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};

   // Control decode; unknown opcodes fall through as no-ops.
   always_comb begin
      reg_write  = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ADD;
      alu_kill   = 1'b0;
      imm        = imm_i;
      case (opcode)
         OP_R: begin
            reg_write = 1'b1;
            case (funct3)
               F3_ADD_SUB: alu_op = instruction[F7_SUB_BIT] ? SUB : ADD;
               F3_AND:     alu_op = AND;
               F3_OR:      alu_op = OR;
               default:    alu_kill = 1'b1;  // unsupported R-type writes zero
            endcase
         end
         OP_IMM: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
         end
         OP_LOAD: begin
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            alu_src    = 1'b1;
            reg_write  = 1'b1;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm       = imm_s;
         end
         OP_BRANCH: begin
            branch = 1'b1;
            alu_op = SUB;
         end
         default: begin
         end
      endcase
   end

   register_file reg_file (
      .clk      (clk),
      .reset    (reset),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (reg_read_data1),
      .rs2_data (reg_read_data2),
      .wr_en    (reg_write),
      .wr_addr  (rd),
      .wr_data  (reg_write_data)
   );

   // ALU
   assign alu_b = alu_src ? imm : reg_read_data2;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ADD: alu_result = reg_read_data1 + alu_b;
         SUB: alu_result = reg_read_data1 - alu_b;
         AND: alu_result = reg_read_data1 & alu_b;
         OR:  alu_result = reg_read_data1 | alu_b;
         default: alu_result = '0;
      endcase
      if (alu_kill) begin
         alu_result = '0;
      end
   end

   assign zero = (alu_result == '0);

   // Data memory: doubleword index, low three address bits ignored.
   assign dbus.addr  = alu_result[DMEM_AW+2:3];
   assign dbus.wdata = reg_read_data2;
   assign dbus.we    = mem_write & reset;
   assign dbus.re    = mem_read;

   data_memory dmem (
      .clk (clk),
      .bus (dbus)
   );

   assign mem_read_data  = dbus.rdata;
   assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;

   assign pc_next = (branch && zero) ? pc_current + imm_b : pc_current + XLEN'(4);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_current <= '0;
      end else begin
         pc_current <= pc_next;
      end
   end

endmodule

// File: tb/tb_rv64_cpu_sequential.sv
// Bench for rv64_cpu_sequential: directed program with a table of expected
// architectural state, hand-written branch / reset sequences, and random
// programs checked against an instruction-level reference interpreter.
module tb_rv64_cpu_sequential;

   typedef enum int {
      K_ADD, K_SUB, K_AND, K_OR, K_RBAD, K_ADDI, K_LD, K_SD, K_BEQ, K_JUNK, K_END
   } kind_t;

   typedef struct {
      kind_t  k;
      int     rd;
      int     rs1;
      int     rs2;
      longint imm;
   } instr_t;

   typedef struct {
      string       name;
      bit          is_mem;
      int          idx;
      logic [63:0] exp;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   instr_t      prog [$];
   logic [63:0] m_reg [32];
   logic [63:0] m_mem [64];
   logic [63:0] m_pc;

   rv64_cpu_sequential dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   function automatic instr_t mk(kind_t k, int rd, int rs1, int rs2, longint imm);
      instr_t i;
      i.k   = k;
      i.rd  = rd;
      i.rs1 = rs1;
      i.rs2 = rs2;
      i.imm = imm;
      return i;
   endfunction

   function automatic logic [31:0] encode(instr_t i);
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] iv;
      logic [11:0] i12;
      logic [12:0] b13;
      rd  = 5'(i.rd);
      rs1 = 5'(i.rs1);
      rs2 = 5'(i.rs2);
      iv  = i.imm;
      i12 = iv[11:0];
      b13 = iv[12:0];
      case (i.k)
         K_ADD:  return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         K_SUB:  return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         K_AND:  return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
         K_OR:   return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
         K_RBAD: return {7'b0000000, rs2, rs1, iv[2:0], rd, 7'b0110011};
         K_ADDI: return {i12, rs1, 3'b000, rd, 7'b0010011};
         K_LD:   return {i12, rs1, 3'b011, rd, 7'b0000011};
         K_SD:   return {i12[11:5], rs2, rs1, 3'b011, i12[4:0], 7'b0100011};
         K_BEQ:  return {b13[12], b13[10:5], rs2, rs1, 3'b000, b13[4:1], b13[11], 7'b1100011};
         K_JUNK: return {iv[24:0], 7'b0110111};
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference interpreter ----------------
   function automatic int fetch_idx();
      return int'((m_pc >> 2) % 64);
   endfunction

   function automatic bit model_at_end();
      int idx;
      idx = fetch_idx();
      return (idx >= prog.size()) || (prog[idx].k == K_END);
   endfunction

   task automatic model_wr(input int rd, input logic [63:0] v);
      if (rd != 0) m_reg[rd] = v;
   endtask

   task automatic model_step();
      instr_t      i;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] ea;
      logic [63:0] nxt;
      i   = prog[fetch_idx()];
      a   = m_reg[i.rs1];
      b   = m_reg[i.rs2];
      ea  = a + 64'(i.imm);
      nxt = m_pc + 64'd4;
      case (i.k)
         K_ADD:  model_wr(i.rd, a + b);
         K_SUB:  model_wr(i.rd, a - b);
         K_AND:  model_wr(i.rd, a & b);
         K_OR:   model_wr(i.rd, a | b);
         K_RBAD: model_wr(i.rd, 64'd0);
         K_ADDI: model_wr(i.rd, ea);
         K_LD:   model_wr(i.rd, m_mem[int'((ea >> 3) % 64)]);
         K_SD:   m_mem[int'((ea >> 3) % 64)] = b;
         K_BEQ:  if (a == b) nxt = m_pc + 64'(i.imm);
         default: ;
      endcase
      m_pc = nxt;
   endtask

   // Hold reset low while the new image is loaded so nothing executes early.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 64; a++) begin
         dut.imem.memory[a] = (a < prog.size()) ? encode(prog[a]) : 32'h0;
      end
      for (int r = 0; r < 32; r++) m_reg[r] = 64'd0;
      m_pc = 64'd0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_checked(input int budget);
      int n;
      n = 0;
      while (1) begin
         chk("pc", dut.pc_current, m_pc);
         if (model_at_end()) begin
            chk("end_instruction", {32'h0, dut.instruction}, 64'd0);
            break;
         end
         if (n == budget) begin
            checks++;
            errors++;
            $display("FAIL run_budget: got %0d cycles, expected end within %0d", n, budget);
            break;
         end
         model_step();
         n++;
         @(negedge clk);
      end
   endtask

   task automatic compare_state(input string tag);
      for (int r = 0; r < 32; r++)
         chk($sformatf("%s_x%0d", tag, r), dut.reg_file.registers[r], m_reg[r]);
      for (int a = 0; a < 64; a++)
         chk($sformatf("%s_dmem%0d", tag, a), dut.dmem.memory[a], m_mem[a]);
   endtask

   task automatic step_to_pc(input logic [63:0] target, input int budget);
      int n;
      n = 0;
      while ((dut.pc_current != target) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      chk("reach_pc", dut.pc_current, target);
   endtask

   initial begin
      vec_t        vecs [$];
      logic [63:0] act;

      for (int a = 0; a < 64; a++) m_mem[a] = 64'd0;

      // Reset state
      #1 reset = 1'b0;
      #1;
      chk("reset_pc", dut.pc_current, 64'd0);
      for (int r = 0; r < 32; r++)
         chk($sformatf("reset_x%0d", r), dut.reg_file.registers[r], 64'd0);
      for (int a = 0; a < 6; a++)
         chk($sformatf("dmem_init%0d", a), dut.dmem.memory[a], 64'd0);

      // Directed 31-instruction program
      prog.delete();
      prog.push_back(mk(K_ADDI, 1, 0, 0, 15));
      prog.push_back(mk(K_ADDI, 2, 0, 0, 25));
      prog.push_back(mk(K_ADDI, 3, 0, 0, 7));
      prog.push_back(mk(K_ADD,  5, 1, 2, 0));
      prog.push_back(mk(K_SUB,  6, 2, 1, 0));
      prog.push_back(mk(K_AND,  7, 1, 3, 0));
      prog.push_back(mk(K_OR,   8, 1, 3, 0));
      prog.push_back(mk(K_SD,   0, 0, 5, 0));
      prog.push_back(mk(K_SD,   0, 0, 6, 8));
      prog.push_back(mk(K_LD,   9, 0, 0, 0));
      prog.push_back(mk(K_LD,  10, 0, 0, 8));
      prog.push_back(mk(K_ADD, 11, 9, 10, 0));
      prog.push_back(mk(K_SUB, 12, 9, 10, 0));
      prog.push_back(mk(K_BEQ,  0, 11, 12, 24));  // pc 52, not taken
      prog.push_back(mk(K_ADDI, 13, 0, 0, 100));
      prog.push_back(mk(K_ADDI, 14, 13, 0, -38));
      prog.push_back(mk(K_ADDI, 15, 14, 0, -44));
      prog.push_back(mk(K_SD,   0, 0, 14, 16));
      prog.push_back(mk(K_SD,   0, 0, 15, 24));
      prog.push_back(mk(K_ADD, 16, 11, 0, 0));
      prog.push_back(mk(K_ADD, 17, 16, 15, 0));
      prog.push_back(mk(K_BEQ,  0, 16, 11, 8));   // pc 84, taken to 92
      prog.push_back(mk(K_ADDI, 18, 0, 0, 99));
      prog.push_back(mk(K_ADDI, 18, 3, 0, -1));
      prog.push_back(mk(K_SD,   0, 0, 14, 32));
      prog.push_back(mk(K_SD,   0, 0, 15, 40));
      prog.push_back(mk(K_LD,  19, 0, 0, 16));
      prog.push_back(mk(K_LD,  20, 0, 0, 24));
      prog.push_back(mk(K_LD,  21, 0, 0, 32));
      prog.push_back(mk(K_LD,  22, 0, 0, 40));
      prog.push_back(mk(K_BEQ,  0, 0, 0, 4));     // pc 120, taken to 124
      prog.push_back(mk(K_END,  0, 0, 0, 0));

      vecs.push_back('{"x1", 1'b0, 1, 64'd15});
      vecs.push_back('{"x2", 1'b0, 2, 64'd25});
      vecs.push_back('{"x3", 1'b0, 3, 64'd7});
      vecs.push_back('{"x5", 1'b0, 5, 64'd40});
      vecs.push_back('{"x6", 1'b0, 6, 64'd10});
      vecs.push_back('{"x7", 1'b0, 7, 64'd7});
      vecs.push_back('{"x8", 1'b0, 8, 64'd15});
      vecs.push_back('{"x9", 1'b0, 9, 64'd40});
      vecs.push_back('{"x10", 1'b0, 10, 64'd10});
      vecs.push_back('{"x11", 1'b0, 11, 64'd50});
      vecs.push_back('{"x12", 1'b0, 12, 64'd30});
      vecs.push_back('{"x13", 1'b0, 13, 64'd100});
      vecs.push_back('{"x14", 1'b0, 14, 64'd62});
      vecs.push_back('{"x15", 1'b0, 15, 64'd18});
      vecs.push_back('{"x16", 1'b0, 16, 64'd50});
      vecs.push_back('{"x17", 1'b0, 17, 64'd68});
      vecs.push_back('{"x18", 1'b0, 18, 64'd6});
      vecs.push_back('{"x19", 1'b0, 19, 64'd62});
      vecs.push_back('{"x20", 1'b0, 20, 64'd18});
      vecs.push_back('{"x21", 1'b0, 21, 64'd62});
      vecs.push_back('{"x22", 1'b0, 22, 64'd18});
      vecs.push_back('{"dmem0", 1'b1, 0, 64'd40});
      vecs.push_back('{"dmem1", 1'b1, 1, 64'd10});
      vecs.push_back('{"dmem2", 1'b1, 2, 64'd62});
      vecs.push_back('{"dmem3", 1'b1, 3, 64'd18});
      vecs.push_back('{"dmem4", 1'b1, 4, 64'd62});
      vecs.push_back('{"dmem5", 1'b1, 5, 64'd18});

      do_reset();
      run_checked(200);
      foreach (vecs[v]) begin
         act = vecs[v].is_mem ? dut.dmem.memory[vecs[v].idx]
                              : dut.reg_file.registers[vecs[v].idx];
         chk(vecs[v].name, act, vecs[v].exp);
      end
      chk("final_pc", dut.pc_current, 64'd124);
      chk("final_instruction", {32'h0, dut.instruction}, 64'd0);

      // Branch sequences
      do_reset();
      step_to_pc(64'd52, 40);
      chk("beq_nt_branch", {63'd0, dut.branch}, 64'd1);
      @(negedge clk);
      chk("beq_nt_pc", dut.pc_current, 64'd56);
      step_to_pc(64'd84, 20);
      @(negedge clk);
      chk("beq_taken_pc", dut.pc_current, 64'd92);
      step_to_pc(64'd120, 20);
      @(negedge clk);
      chk("beq_end_pc", dut.pc_current, 64'd124);
      chk("beq_end_instruction", {32'h0, dut.instruction}, 64'd0);

      // Asynchronous reset between clock edges, mid-program
      do_reset();
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_pc", dut.pc_current, 64'd0);
      for (int r = 0; r < 32; r++)
         chk($sformatf("midrst_x%0d", r), dut.reg_file.registers[r], 64'd0);
      foreach (vecs[v]) begin
         if (vecs[v].is_mem)
            chk({"midrst_", vecs[v].name}, dut.dmem.memory[vecs[v].idx], vecs[v].exp);
      end
      @(negedge clk);
      reset = 1'b1;
      chk("midrst_restart_instruction", {32'h0, dut.instruction}, {32'h0, encode(prog[0])});
      step_to_pc(64'd124, 60);
      chk("midrst_x17", dut.reg_file.registers[17], 64'd68);
      chk("midrst_x22", dut.reg_file.registers[22], 64'd18);

      // x0 write is discarded
      prog.delete();
      prog.push_back(mk(K_ADDI, 0, 0, 0, 5));
      prog.push_back(mk(K_ADDI, 3, 0, 0, 5));
      prog.push_back(mk(K_ADD,  4, 0, 3, 0));
      prog.push_back(mk(K_END,  0, 0, 0, 0));
      do_reset();
      run_checked(20);
      chk("x0_after_write", dut.reg_file.registers[0], 64'd0);
      chk("x4_from_x0", dut.reg_file.registers[4], 64'd5);
      compare_state("x0test");

      // Random programs against the reference interpreter
      for (int t = 0; t < 4; t++) begin
         int n;
         prog.delete();
         n = 20 + int'($urandom_range(0, 8));
         for (int i = 0; i < n; i++) begin
            instr_t in;
            in.k   = kind_t'($urandom_range(0, 9));
            in.rd  = int'($urandom_range(0, 7));
            in.rs1 = int'($urandom_range(0, 7));
            in.rs2 = int'($urandom_range(0, 7));
            in.imm = longint'($urandom_range(0, 4095)) - 2048;
            if (in.k == K_BEQ) begin
               in.imm = 4 * longint'($urandom_range(1, 3));
               if ($urandom_range(0, 1) == 1) in.rs2 = in.rs1;
            end else if (in.k == K_RBAD) begin
               in.imm = longint'($urandom_range(1, 5));
            end else if (in.k == K_JUNK) begin
               in.imm = longint'($urandom);
            end
            prog.push_back(in);
         end
         prog.push_back(mk(K_END, 0, 0, 0, 0));
         do_reset();
         run_checked(200);
         compare_state($sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv64_cpu_sequential.md
# rv64_cpu_sequential

Single-cycle RV64 integer CPU subset (add, sub, and, or, addi, ld, sd, beq) with internal instruction memory, data memory and register file. Each instruction is fetched, decoded, executed and retired in exactly one clock cycle. It is the top-level processor block. The bench drives only clock and reset, preloads programs and inspects state through fixed hierarchical names.

## Interface
- No parameters. Fixed constants: XLEN 64, IMEM_DEPTH 64 words × 32 b, DMEM_DEPTH 64 doublewords × 64 b.
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- No other ports. These hierarchical names are required and visible to the bench:
  - Instances: `imem.memory[]`, `dmem.memory[]`, `reg_file.registers[]`.
  - Signals: `pc_current`, `instruction`, `rs1`, `rs2`, `rd`, `reg_write`, `reg_write_data`, `branch`, `mem_read`, `mem_to_reg`, `mem_write`, `alu_src`, `alu_result`, `reg_read_data2`, `mem_read_data`.

## Operation
- Fetch: `instruction = imem.memory[pc_current[7:2]]`, read combinationally.
- Decode fields: `rs1=[19:15]`, `rs2=[24:20]`, `rd=[11:7]`.
- Immediates, all sign-extended to 64 bits:
  - I-type: [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
- Opcode 0110011, R-type, `reg_write=1`:
  - funct3 000: add, or sub when [30]=1.
  - funct3 111: and.
  - funct3 110: or.
  - Other funct3 values write 0.
- Opcode 0010011 (addi): `alu_src=1`, `reg_write=1`, computes rs1+immI.
- Opcode 0000011 (ld): `mem_read=1`, `mem_to_reg=1`, `alu_src=1`, `reg_write=1`. Address = rs1+immI. Data = `dmem.memory[alu_result[8:3]]`, read combinationally.
- Opcode 0100011 (sd): `mem_write=1`, `alu_src=1`. Writes `reg_read_data2` to `dmem.memory[alu_result[8:3]]`. Low 3 address bits are ignored.
- Opcode 1100011 (beq): `branch=1`. ALU computes rs1−rs2. Branch is taken when the result is zero.
- All other opcodes, including the all-zero word, are no-ops: no register or memory write, and PC+4. The all-zero word marks program end for the bench.
- Register file:
  - Two combinational read ports.
  - One write port, active on the clock edge when `reg_write`=1.
  - x0 reads 0 and writes to x0 are discarded.
- Writeback: `reg_write_data = mem_to_reg ? mem_read_data : alu_result`.
- Next PC: `branch & zero ? pc+immB : pc+4`.
- All arithmetic is 64-bit two's complement with wrap-around. There is no overflow detection.

## Timing
- Latency is one cycle per instruction (CPI = 1).
- On each rising `clk` edge with `reset` high, these update together:
  - PC.
  - Register write.
  - Data-memory write.
- Reads happen combinationally before the edge, so an instruction sees the results of all earlier instructions.
- `reset` low, asynchronous: PC=0 and all registers are cleared to 0 immediately.
- Reset does not modify imem or dmem. dmem starts at zero at time 0. imem is loaded by the bench.
- Reset mid-program: the PC restarts at 0. Memory contents persist.
- PC wraps modulo the IMEM size; index bits [7:2] are used.
- A branch to its own address loops indefinitely.

## Structure
- Shared package `rv_pkg`:
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - funct3/funct7 constants.
  - `alu_op_t` enum: ADD, SUB, AND, OR.
- Sub-modules, instanced with the required names:
  - `register_file` as `reg_file`.
  - `instruction_memory` as `imem`.
  - `data_memory` as `dmem`.
- Control decoder, immediate generator and ALU are inline.

## Test plan
- Arithmetic program: addi x1=15, x2=25, x3=7, then add, sub, and, or. Required: x5=40, x6=10, x7=7, x8=15.
- Store/load:
  - sd x5,0(x0) and sd x6,8(x0) -> dmem[0]=40, dmem[1]=10.
  - ld x9,0(x0) and ld x10,8(x0) -> x9=40, x10=10.
  - add x11 and sub x12 -> x11=50, x12=30.
- beq not taken:
  - beq x11,x12,+24 with 50≠30 -> PC advances +4.
  - x13=100, x14=62, x15=18.
  - dmem[2]=62, dmem[3]=18.
- Full 31-instruction program ending with beq x0,x0,+4 followed by an all-zero word. Required:
  - x16=50, x17=68, x18=6, x19=62, x20=18, x21=62, x22=18.
  - dmem[4]=62, dmem[5]=18.
  - Taken branch from PC 120 reaches PC 124, where `instruction`=0.
- x0 write: addi x0,x0,5 -> x0 remains 0.
- Asynchronous reset asserted mid-program, between clock edges:
  - PC=0 and all registers 0 immediately.
  - dmem unchanged.
  - Execution restarts from imem[0] after release.
